// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg: shared timing constants, colour and state types for the VGA  |
// | display path.                                                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    // RRRGGGBB
    typedef logic [7:0] rgb332_t;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_RUN   = 1'b1
    } vga_state_e;

    // Per-pixel control bits that travel down the pipeline beside the colour.
    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input int               lo,
                                       input int               hi);
        return (pos >= CNT_W'(lo)) && (pos <= CNT_W'(hi));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_layer_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_layer_mux: fixed-priority selection of one colour from the sprite |
// | layers; layer 0 wins, background when no layer hits.                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vga_layer_mux
    import vga_pkg::*;
#(
    parameter int N_LAYERS = 4
) (
    input  logic [N_LAYERS-1:0]   hit_i,
    input  logic [8*N_LAYERS-1:0] rgb_i,
    input  rgb332_t               bg_i,
    output rgb332_t               rgb_o
);

    rgb332_t w_layer_rgb [N_LAYERS];

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_unpack
        assign w_layer_rgb[g] = rgb_i[8*g +: 8];
    end

    // Scan from the lowest-priority layer upward so layer 0 is applied last.
    always_comb begin
        rgb_o = bg_i;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (hit_i[i]) begin
                rgb_o = w_layer_rgb[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_display_ctrl: VGA timing generator, layer arbitration and         |
// | registered RGB/sync outputs with sync aligned to colour.              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vga_display_ctrl
    import vga_pkg::*;
#(
    parameter int      H_ACTIVE = DEF_H_ACTIVE,
    parameter int      H_FP     = DEF_H_FP,
    parameter int      H_SYNC   = DEF_H_SYNC,
    parameter int      H_BP     = DEF_H_BP,
    parameter int      V_ACTIVE = DEF_V_ACTIVE,
    parameter int      V_FP     = DEF_V_FP,
    parameter int      V_SYNC   = DEF_V_SYNC,
    parameter int      V_BP     = DEF_V_BP,
    parameter int      N_LAYERS = 4,
    parameter rgb332_t BG_COLOR = 8'hFF
) (
    input  logic                  clk,
    input  logic                  btnR,
    input  logic                  pix_en,
    output logic [CNT_W-1:0]      px_x,
    output logic [CNT_W-1:0]      px_y,
    output logic                  px_active,
    output logic                  frame_start,
    output logic                  vblank_start,
    input  logic [N_LAYERS-1:0]   layer_hit,
    input  logic [8*N_LAYERS-1:0] layer_rgb,
    output logic                  Hsync,
    output logic                  Vsync,
    output logic [2:0]            vgaRed,
    output logic [2:0]            vgaGreen,
    output logic [1:0]            vgaBlue
);

    localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_start = H_ACTIVE + H_FP;
    localparam int c_hs_end   = c_hs_start + H_SYNC - 1;
    localparam int c_vs_start = V_ACTIVE + V_FP;
    localparam int c_vs_end   = c_vs_start + V_SYNC - 1;

    localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_active = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_active = CNT_W'(V_ACTIVE);

    if ((c_h_total > 1023) || (c_v_total > 1023) || (N_LAYERS < 1)) begin : g_bad_timing
        $error("vga_display_ctrl: timing totals exceed 10-bit counters or no layers");
    end

    logic [CNT_W-1:0]      h_q, h_d;
    logic [CNT_W-1:0]      v_q, v_d;
    vga_ctl_t              ctl0_q, ctl0_d;
    vga_ctl_t              ctl1_q;
    logic                  hs2_q, vs2_q;
    logic                  frame_start_q, frame_start_d;
    logic                  vblank_start_q, vblank_start_d;
    logic [N_LAYERS-1:0]   hit1_q;
    logic [8*N_LAYERS-1:0] rgb1_q;
    rgb332_t               w_mux_rgb;
    rgb332_t               rgb2_q, rgb2_d;
    vga_state_e            state_q, state_d;
    logic                  w_color_en;

    // Stage 0 control bits are derived from the next count so they line up with it.
    always_comb begin
        h_d = (h_q == c_h_last) ? '0 : h_q + CNT_W'(1);
        v_d = v_q;
        if (h_q == c_h_last) begin
            v_d = (v_q == c_v_last) ? '0 : v_q + CNT_W'(1);
        end
        ctl0_d.active  = (h_d < c_h_active) && (v_d < c_v_active);
        ctl0_d.hsync_n = !in_window(h_d, c_hs_start, c_hs_end);
        ctl0_d.vsync_n = !in_window(v_d, c_vs_start, c_vs_end);
        frame_start_d  = pix_en && (h_d == '0) && (v_d == '0);
        vblank_start_d = pix_en && (h_d == '0) && (v_d == c_v_active);
    end

    vga_layer_mux #(
        .N_LAYERS (N_LAYERS)
    ) u_layer_mux (
        .hit_i (hit1_q),
        .rgb_i (rgb1_q),
        .bg_i  (BG_COLOR),
        .rgb_o (w_mux_rgb)
    );

    assign rgb2_d = (w_color_en && ctl1_q.active) ? w_mux_rgb : '0;

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            h_q            <= '0;
            v_q            <= '0;
            ctl0_q         <= CTL_IDLE;
            ctl1_q         <= CTL_IDLE;
            hs2_q          <= 1'b1;
            vs2_q          <= 1'b1;
            hit1_q         <= '0;
            rgb1_q         <= '0;
            rgb2_q         <= '0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            if (pix_en) begin
                h_q    <= h_d;
                v_q    <= v_d;
                ctl0_q <= ctl0_d;
                ctl1_q <= ctl0_q;
                hit1_q <= layer_hit;
                rgb1_q <= layer_rgb;
                hs2_q  <= ctl1_q.hsync_n;
                vs2_q  <= ctl1_q.vsync_n;
                rgb2_q <= rgb2_d;
            end
        end
    end

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Colour stays dark until a complete frame can be drawn from its first line.
    always_comb begin
        state_d    = state_q;
        w_color_en = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (frame_start_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                w_color_en = 1'b1;
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase
    end

    assign px_x         = h_q;
    assign px_y         = v_q;
    assign px_active    = ctl0_q.active;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign Hsync        = hs2_q;
    assign Vsync        = vs2_q;
    assign vgaRed       = rgb2_q[7:5];
    assign vgaGreen     = rgb2_q[4:2];
    assign vgaBlue      = rgb2_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_display_ctrl: directed bench on a reduced raster              |
// | (32x12 total, 20x6 active) with a pixel-level reference model.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_vga_display_ctrl;

    localparam int HA = 20, HF = 3, HSW = 5, HB = 4;
    localparam int VA = 6,  VF = 2, VSW = 2, VB = 2;
    localparam int HT = 32, VT = 12;
    localparam int HS_LO = 23, HS_HI = 27;
    localparam int VS_LO = 8,  VS_HI = 9;

    logic        clk = 1'b0;
    logic        btnR;
    logic        pix_en;
    logic [3:0]  layer_hit;
    logic [31:0] layer_rgb;
    logic [9:0]  px_x, px_y;
    logic        px_active, frame_start, vblank_start;
    logic        Hsync, Vsync;
    logic [2:0]  vgaRed, vgaGreen;
    logic [1:0]  vgaBlue;

    always #5 clk = ~clk;

    vga_display_ctrl #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .N_LAYERS (4),  .BG_COLOR (8'hFF)
    ) dut (
        .clk          (clk),
        .btnR         (btnR),
        .pix_en       (pix_en),
        .px_x         (px_x),
        .px_y         (px_y),
        .px_active    (px_active),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .layer_hit    (layer_hit),
        .layer_rgb    (layer_rgb),
        .Hsync        (Hsync),
        .Vsync        (Vsync),
        .vgaRed       (vgaRed),
        .vgaGreen     (vgaGreen),
        .vgaBlue      (vgaBlue)
    );

    int n_vec = 0;
    int n_err = 0;

    int   m_h, m_v, m_frame, mode;
    logic m_act, m_fs, m_vb;
    logic [7:0] d1_rgb, out_rgb;
    logic d1_hs, d1_vs, out_hs, out_vs;
    int   fs_cnt, vb_cnt, hs_low, vs_low;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", tag, got, exp, m_h, m_v);
        end
    endtask

    function automatic logic [7:0] ref_color(input logic [3:0] hit, input logic [31:0] rgb);
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) return rgb[8*i +: 8];
        end
        return 8'hFF;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_frame = 0; m_act = 1'b0; m_fs = 1'b0; m_vb = 1'b0;
        d1_rgb = 8'h00; d1_hs = 1'b1; d1_vs = 1'b1;
        out_rgb = 8'h00; out_hs = 1'b1; out_vs = 1'b1;
    endtask

    // Layer responses for the coordinate the model says is currently presented.
    task automatic drive_layers();
        layer_rgb = 32'h031CE05A;
        if (mode == 0) begin
            layer_hit = 4'b0001;
        end else if (m_h == 5) begin
            layer_hit = 4'b0110;
        end else if (m_h == 9) begin
            layer_hit = 4'b1111;
        end else if (m_h >= HA || m_v >= VA) begin
            layer_hit = 4'b0001;
        end else begin
            layer_hit = 4'b0000;
        end
    endtask

    task automatic check_pins();
        chk("px_x", px_x, m_h);
        chk("px_y", px_y, m_v);
        chk("px_active", px_active, m_act);
        chk("frame_start", frame_start, m_fs);
        chk("vblank_start", vblank_start, m_vb);
        chk("Hsync", Hsync, out_hs);
        chk("Vsync", Vsync, out_vs);
        chk("rgb", {vgaRed, vgaGreen, vgaBlue}, out_rgb);
    endtask

    // Entered and left at 1 time unit after a rising edge; one tick = 4 clocks.
    task automatic do_tick();
        logic [7:0] cur_rgb;
        logic       cur_hs, cur_vs;
        logic [7:0] pins;
        cur_rgb = (m_frame > 0 && m_act) ? ref_color(layer_hit, layer_rgb) : 8'h00;
        cur_hs  = !(m_h >= HS_LO && m_h <= HS_HI);
        cur_vs  = !(m_v >= VS_LO && m_v <= VS_HI);
        pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        out_rgb = d1_rgb; out_hs = d1_hs; out_vs = d1_vs;
        d1_rgb  = cur_rgb; d1_hs = cur_hs; d1_vs = cur_vs;
        m_h++;
        if (m_h == HT) begin
            m_h = 0;
            m_v++;
            if (m_v == VT) m_v = 0;
        end
        m_fs  = (m_h == 0 && m_v == 0);
        m_vb  = (m_h == 0 && m_v == VA);
        if (m_fs) m_frame++;
        m_act = (m_h < HA && m_v < VA);
        check_pins();
        if (frame_start)  fs_cnt++;
        if (vblank_start) vb_cnt++;
        if (!Hsync) hs_low++;
        if (!Vsync) vs_low++;
        pins = {vgaRed, vgaGreen, vgaBlue};
        if (m_frame == 0) begin
            chk("blank_rgb", pins, 8'h00);
        end else if (m_v < VA) begin
            if (mode == 0 && m_h >= 2 && m_h < HA + 2) chk("layer0_px", pins, 8'h5A);
            if (mode == 1) begin
                case (m_h)
                    7: begin
                        chk("prio_e0", pins, 8'hE0);
                        chk("prio_red", vgaRed, 3'b111);
                    end
                    8:  chk("bg_color", pins, 8'hFF);
                    11: chk("all_hits", pins, 8'h5A);
                    21: chk("last_active", pins, 8'hFF);
                    22: chk("hit_outside", pins, 8'h00);
                    default: ;
                endcase
            end
        end
        @(posedge clk); #1;
        m_fs = 1'b0;
        m_vb = 1'b0;
        chk("fs_width", frame_start, 1'b0);
        chk("vb_width", vblank_start, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive_layers();
    endtask

    task automatic run_frame();
        fs_cnt = 0; vb_cnt = 0; hs_low = 0; vs_low = 0;
        for (int i = 0; i < HT * VT; i++) do_tick();
        chk("fs_per_frame", fs_cnt, 1);
        chk("vb_per_frame", vb_cnt, 1);
        chk("hs_low_ticks", hs_low, HSW * VT);
        chk("vs_low_ticks", vs_low, VSW * HT);
    endtask

    task automatic tick_until(input int h, input int v);
        for (int i = 0; i < HT * VT && !(m_h == h && m_v == v); i++) do_tick();
        chk("reach_x", px_x, h);
        chk("reach_y", px_y, v);
    endtask

    initial begin
        btnR = 1'b0; pix_en = 1'b0; mode = 0;
        layer_hit = 4'b0000; layer_rgb = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_pins();
        btnR = 1'b1;
        drive_layers();

        run_frame();
        run_frame();

        mode = 1;
        drive_layers();
        run_frame();

        tick_until(10, 2);
        layer_hit = 4'b1000;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            chk("hold_fs", frame_start, 1'b0);
            chk("hold_vb", vblank_start, 1'b0);
        end
        check_pins();
        drive_layers();
        do_tick();
        chk("resume_x", px_x, 11);

        tick_until(12, 3);
        #2;
        btnR = 1'b0;
        #1;
        model_reset();
        check_pins();
        @(posedge clk); #1;
        check_pins();
        btnR = 1'b1;
        mode = 0;
        drive_layers();
        run_frame();
        for (int i = 0; i < 3 * HT; i++) do_tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
